serial_addsub32: RTL and testbench
==================================

# serial_addsub32

Multi-cycle 32-bit adder/subtractor that processes one DIGIT-bit slice per clock, trading the long carry chain of the combinational 32-bit ripple-carry adder for a short registered one. It is the sequential counterpart of that adder and shares its operand/carry naming. It sits behind a valid/ready handshake so a controller or bench can issue operations and collect results. Add mode produces results bit-identical to the combinational adder.

## Interface
- WIDTH, 32, operand width.
- DIGIT, 4, bits processed per cycle; must divide WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- startValid  in  1  request carries valid operands.
- startReady  out  1  unit can accept a request.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- carryInput  in  1  carry-in (add) or borrow-in (subtract).
- subtract  in  1  0 = add, 1 = subtract.
- sum  out  WIDTH  result.
- carryOutput  out  1  carry-out; in subtract mode, 1 = no borrow.
- overflow  out  1  signed overflow; present only with the configuration macro.
- outValid  out  1  result is valid.
- outReady  in  1  consumer accepts the result.

## Operation
- One clock; reset is synchronous and active-low.
- States:
  - IDLE: startReady=1. startValid at an edge → RUN.
  - RUN: one digit per edge, for WIDTH/DIGIT edges → DONE.
  - DONE: outValid=1. outReady at an edge → IDLE.
- Accept edge:
  - Latch a, b, subtract and carryInput.
  - Digit counter = 0.
  - In subtract mode, store ~b as the second operand and ~carryInput as the initial carry.
  - Later changes on the inputs are ignored.
- Arithmetic:
  - Add: {carryOutput,sum} = a + b + carryInput, modulo 2^(WIDTH+1).
  - Subtract: {carryOutput,sum} = a + ~b + ~carryInput, i.e. sum = a − b − carryInput mod 2^WIDTH.
  - Carry-out of digit k is registered and feeds digit k+1.
  - Digits are processed LSB first.
- Result:
  - sum, carryOutput and overflow are registered.
  - They are stable while outValid=1.
  - They hold their value after leaving DONE until the next result is written.
- startReady is 1 only in IDLE. startValid in RUN or DONE is ignored, not queued.
- Reset (also mid-RUN or in DONE):
  - State → IDLE.
  - sum=0, carryOutput=0, overflow=0, outValid=0, startReady=1 in the cycle after the reset edge.
  - The in-flight operation is discarded.
- Wrap-around: the digit counter saturates at its last value, and the RUN→DONE transition happens at that last digit. The counter never wraps into an extra digit.

## Timing
- The accept edge is E0. Digit k is computed at edge E(k+1).
- outValid rises after edge E(WIDTH/DIGIT), i.e. E8 with defaults.
- Results are held indefinitely while outReady=0.
- DONE→IDLE costs one edge; startReady is high in the following cycle.
- Minimum issue interval: WIDTH/DIGIT + 2 cycles (10 with defaults), with outReady tied high.
- No combinational path from any input to any output.

## Configuration
- OVERFLOW_FLAG_EN:
  - When defined, the overflow port exists and is registered at the final digit:
    - overflow = carry into the MSB XOR carry out of the MSB.
    - It is cleared on reset.
  - When undefined, the port and its logic are absent. All other behaviour is unchanged.

## Structure
- Shared package (serial_addsub_pkg):
  - state enum (IDLE, RUN, DONE).
  - WIDTH/DIGIT defaults.
  - the DIGITS = WIDTH/DIGIT constant.
  - the counter width derived from it.
- Sub-module addsub_digit: a combinational DIGIT-bit ripple slice (a, b, cin → s, cout, plus the MSB carry-in used for overflow). It is instantiated once in the sequential top.

## Test plan
- Reset, then add a=2212768, b=3612427, cin=0 → after 8 edges outValid=1, sum=5825195, carryOutput=0.
- Add a=b=32'hFFFFFFFF, cin=0 → sum=32'hFFFFFFFE, carryOutput=1. With cin=1 → sum=32'hFFFFFFFF, carryOutput=1.
- Subtract a=655355467, b=655354378, cin=0 → sum=1089, carryOutput=1. Subtract a=5, b=7 → sum=32'hFFFFFFFE, carryOutput=0.
- OVERFLOW_FLAG_EN defined:
  - Add a=32'h7FFFFFFF, b=1 → sum=32'h80000000, overflow=1, carryOutput=0.
  - Add a=32'h80000000, b=32'h80000000 → sum=0, overflow=1, carryOutput=1.
- Handshake:
  - Hold outReady=0 for 5 cycles → outValid and sum stay stable.
  - startValid during RUN is ignored.
  - Changing a during RUN leaves the result unaffected.
  - Back-to-back requests with outReady=1 are issued every 10 cycles.
- Drop rst_n at digit 4 of an add → next cycle state IDLE, outValid=0, sum=0, startReady=1. A fresh add then gives the correct result.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and constants for the digit-serial
// 32-bit adder/subtractor (FSM state encoding, default geometry).
package serial_addsub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;
  localparam int DIGITS    = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub32_digit.sv
// addsub_digit: combinational DIGIT-bit ripple slice. Also exposes the
// carry into the slice MSB so the top can form the signed overflow flag.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  // Ripple the carry through the slice, LSB first.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout    = c[DIGIT];
    msb_cin = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_addsub32.sv
// serial_addsub32: digit-serial 32-bit adder/subtractor behind a
// valid/ready handshake; one DIGIT-bit slice per clock, LSB first.
// Optional feature macro: OVERFLOW_FLAG_EN adds a registered signed
// overflow output.
//
//   state | meaning
//   IDLE  | ready for a request (startReady=1)
//   RUN   | one digit per edge, WIDTH/DIGIT edges
//   DONE  | result valid (outValid=1), waiting for outReady
module serial_addsub32
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  input  logic             subtract,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             outValid,
  input  logic             outReady
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state, state_nxt;
  logic   accept, step, last;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  logic [DIGIT-1:0] d_s;
  logic             d_cout;
  logic             d_msb;

  // a_q and b_q shift right one digit per step, so the active digit is
  // always at the bottom; result digits enter a_q from the top.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .cin     (carry_q),
    .s       (d_s),
    .cout    (d_cout),
    .msb_cin (d_msb)
  );

`ifndef OVERFLOW_FLAG_EN
  logic msb_unused;
  assign msb_unused = d_msb;
`endif

  assign last = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs, all derived from the state register.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    step       = 1'b0;
    startReady = 1'b0;
    outValid   = 1'b0;
    case (state)
      IDLE: begin
        startReady = 1'b1;
        if (startValid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-digit shift/carry, and result write on the last digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum         <= '0;
      carryOutput <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      overflow    <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      a_q     <= a;
      b_q     <= subtract ? ~b : b;
      carry_q <= subtract ? ~carryInput : carryInput;
    end else if (step) begin
      a_q     <= {d_s, a_q[WIDTH-1:DIGIT]};
      b_q     <= b_q >> DIGIT;
      carry_q <= d_cout;
      if (last) begin
        sum         <= {d_s, a_q[WIDTH-1:DIGIT]};
        carryOutput <= d_cout;
`ifdef OVERFLOW_FLAG_EN
        overflow    <= d_cout ^ d_msb;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub32.sv
// tb_serial_addsub32: directed bench for serial_addsub32 (default 32/4).
module tb_serial_addsub32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startValid;
  logic        startReady;
  logic [31:0] a, b;
  logic        carryInput;
  logic        subtract;
  logic [31:0] sum;
  logic        carryOutput;
  logic        outValid;
  logic        outReady;
`ifdef OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc[$];

  serial_addsub32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .startValid  (startValid),
    .startReady  (startReady),
    .a           (a),
    .b           (b),
    .carryInput  (carryInput),
    .subtract    (subtract),
    .sum         (sum),
    .carryOutput (carryOutput),
`ifdef OVERFLOW_FLAG_EN
    .overflow    (overflow),
`endif
    .outValid    (outValid),
    .outReady    (outReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && startValid && startReady) acc_cyc.push_back(cyc);
  end

  function automatic logic ovf_now();
`ifdef OVERFLOW_FLAG_EN
    return overflow;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tcin, input logic tsub, input bit disturb,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int lat);
    int n = 0;
    while (!startReady && n < 40) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb_v; carryInput = tcin; subtract = tsub; startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 40) begin
      if (disturb && lat == 3) begin
        startValid = 1'b1; a = ~ta; b = 32'h1234_5678;
        subtract = ~tsub; carryInput = ~tcin;
      end
      @(posedge clk); #1; lat++;
    end
    startValid = 1'b0;
    rs = sum; rc = carryOutput; ro = ovf_now();
  endtask

  task automatic retire();
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (startReady !== 1'b1) begin errors++; $display("FAIL reset_startReady got %b want 1", startReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++; if (carryOutput !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carryOutput); end
`ifdef OVERFLOW_FLAG_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // a, b, cin, sub, expected sum, carry, overflow
  typedef struct {
    logic [31:0] va, vb;
    logic cin, sub;
    logic [31:0] es;
    logic ec, eo;
  } vec_t;

  task automatic test_arith();
    vec_t v[10];
    logic [31:0] rs; logic rc, ro; int lat;
    v[0] = '{32'd2212768, 32'd3612427, 1'b0, 1'b0, 32'd5825195, 1'b0, 1'b0};
    v[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    v[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    v[3] = '{32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    v[5] = '{32'd655355467, 32'd655354378, 1'b0, 1'b1, 32'd1089, 1'b1, 1'b0};
    v[6] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[7] = '{32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0};
    v[8] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0};
    v[9] = '{32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].va, v[i].vb, v[i].cin, v[i].sub, 1'b0, rs, rc, ro, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL arith%0d_latency got %0d want 8", i, lat); end
      checks++; if (rs !== v[i].es) begin errors++; $display("FAIL arith%0d_sum got %h want %h", i, rs, v[i].es); end
      checks++; if (rc !== v[i].ec) begin errors++; $display("FAIL arith%0d_carry got %b want %b", i, rc, v[i].ec); end
`ifdef OVERFLOW_FLAG_EN
      checks++; if (ro !== v[i].eo) begin errors++; $display("FAIL arith%0d_overflow got %b want %b", i, ro, v[i].eo); end
`endif
      retire();
    end
  endtask

  task automatic test_hold();
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(32'd40000, 32'd2345, 1'b1, 1'b0, 1'b0, rs, rc, ro, lat);
    startValid = 1'b1; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (outValid !== 1'b1 || sum !== 32'd42346 || startReady !== 1'b0)
      begin errors++; $display("FAIL hold%0d got valid=%b sum=%0d ready=%b want 1 42346 0", i, outValid, sum, startReady); end
    end
    startValid = 1'b0;
    retire();
    checks++;
    if (outValid !== 1'b0 || sum !== 32'd42346 || startReady !== 1'b1)
    begin errors++; $display("FAIL hold_after got valid=%b sum=%0d ready=%b want 0 42346 1", outValid, sum, startReady); end
  endtask

  task automatic test_run_ignore();
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(32'd100, 32'd23, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", lat); end
    checks++; if (rs !== 32'd123 || rc !== 1'b0) begin errors++; $display("FAIL ignore_result got %0d/%b want 123/0", rs, rc); end
    retire();
    @(posedge clk); #1;
    checks++; if (startReady !== 1'b1 || outValid !== 1'b0) begin errors++; $display("FAIL ignore_not_queued got ready=%b valid=%b want 1 0", startReady, outValid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[3], exp_s[3];
    int n;
    va[0] = 32'd1000; va[1] = 32'd2000; va[2] = 32'hFFFFFFF0;
    exp_s[0] = 32'd1007; exp_s[1] = 32'd2007; exp_s[2] = 32'hFFFFFFF7;
    acc_cyc.delete();
    outReady = 1'b1;
    a = va[0]; b = 32'd7; carryInput = 1'b0; subtract = 1'b0; startValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!outValid && n < 40);
      checks++; if (outValid !== 1'b1 || sum !== exp_s[i]) begin errors++; $display("FAIL b2b%0d_sum got valid=%b sum=%h want 1 %h", i, outValid, sum, exp_s[i]); end
      if (i < 2) a = va[i+1];
      else startValid = 1'b0;
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    checks++; if (acc_cyc.size() !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size()); end
    else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 10) begin errors++; $display("FAIL b2b_interval0 got %0d want 10", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_cyc[2] - acc_cyc[1] !== 10) begin errors++; $display("FAIL b2b_interval1 got %0d want 10", acc_cyc[2] - acc_cyc[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rs; logic rc, ro; int lat;
    a = 32'd1000; b = 32'd2000; carryInput = 1'b0; subtract = 1'b0; startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (startReady !== 1'b1 || outValid !== 1'b0 || sum !== 32'd0 || carryOutput !== 1'b0)
    begin errors++; $display("FAIL midreset got ready=%b valid=%b sum=%h co=%b want 1 0 0 0", startReady, outValid, sum, carryOutput); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd12345678, 32'd87654321, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (lat !== 8 || rs !== 32'd99999999 || rc !== 1'b0) begin errors++; $display("FAIL midreset_fresh got lat=%0d sum=%0d co=%b want 8 99999999 0", lat, rs, rc); end
    retire();
  endtask

  initial begin
    rst_n = 1'b0; startValid = 1'b0; a = '0; b = '0;
    carryInput = 1'b0; subtract = 1'b0; outReady = 1'b0;
    test_reset();
    test_arith();
    test_hold();
    test_run_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
